// File: rtl/regfile.sv
// 32-entry integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, optional write-to-read bypass.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_wren_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // A write only takes effect out of reset and never to x0; this same
  // qualifier gates the bypass path so reset also suppresses forwarding.
  logic wr_en;
  assign wr_en = rst_ni & rd_wren_i & (rd_addr_i != '0);

  // Next-state of the array: reset clears everything and wins over a write.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        regs_d[i] = '0;
      end
    end else if (wr_en) begin
      regs_d[rd_addr_i] = rd_data_i;
    end
    regs_d[0] = '0;
  end

  // Register array update on the rising edge (reset is folded into regs_d).
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NREG; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // Read port 1: x0 forced to zero, then optional same-cycle forwarding.
  always_comb begin
    rs1_data_o = regs_q[rs1_addr_i];
    if (rs1_addr_i == '0) begin
      rs1_data_o = '0;
    end else if (BYPASS && wr_en && (rs1_addr_i == rd_addr_i)) begin
      rs1_data_o = rd_data_i;
    end
  end

  // Read port 2: evaluated independently of port 1.
  always_comb begin
    rs2_data_o = regs_q[rs2_addr_i];
    if (rs2_addr_i == '0) begin
      rs2_data_o = '0;
    end else if (BYPASS && wr_en && (rs2_addr_i == rd_addr_i)) begin
      rs2_data_o = rd_data_i;
    end
  end

endmodule
